// File: rtl/kim_panel_if.sv
// Front-panel signal bundle between the board switches and the KIM-1 core.
// master drives raw active-low switches and consumes conditioned levels; slave is the conditioner.
interface kim_panel_if;
  logic       rs_key_n;
  logic       st_key_n;
  logic       sst_sw_n;
  logic       tty_en_n;
  logic       key_n;
  logic       kim_reset;
  logic       kim_nmi;
  logic       sst_on;
  logic       tty_on;
  logic [4:0] press_pulse;

  modport master (
    output rs_key_n, st_key_n, sst_sw_n, tty_en_n, key_n,
    input  kim_reset, kim_nmi, sst_on, tty_on, press_pulse
  );

  modport slave (
    input  rs_key_n, st_key_n, sst_sw_n, tty_en_n, key_n,
    output kim_reset, kim_nmi, sst_on, tty_on, press_pulse
  );
endinterface

// File: rtl/kim_panel_conditioner.sv
// Synchronise, debounce and stretch the KIM-1 front-panel switches into clean core controls.
// Define PANEL_POR_EN to have reset_n also produce a RESET_HOLD-cycle power-on core reset.
module kim_panel_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 5000,
  parameter int unsigned RESET_HOLD      = 16
) (
  input logic        clk,
  input logic        reset_n,
  kim_panel_if.slave panel
);

  localparam int unsigned NumCh = 5;
  localparam int unsigned ChRs  = 0;
  localparam int unsigned ChSt  = 1;
  localparam int unsigned ChSst = 2;
  localparam int unsigned ChTty = 3;
  localparam int unsigned ChKey = 4;

  localparam int unsigned CntW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HoldW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  localparam logic [CntW-1:0]  CntLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_HOLD - 1);

  typedef enum logic [1:0] {
    StRun,
    StAssert,
    StStretch
  } state_e;

  logic [NumCh-1:0]           raw;
  logic [NumCh-1:0]           sync1_q;
  logic [NumCh-1:0]           sync2_q;
  logic [NumCh-1:0]           stable_q;
  logic [NumCh-1:0]           stable_d;
  logic [NumCh-1:0]           stable_dly_q;
  logic [NumCh-1:0]           press_q;
  logic [NumCh-1:0][CntW-1:0] cnt_q;
  logic [NumCh-1:0][CntW-1:0] cnt_d;

  logic             rst_req;
  state_e           state_q;
  logic [HoldW-1:0] hold_q;
  logic             kim_reset_q;

  assign raw = {panel.key_n, panel.tty_en_n, panel.sst_sw_n, panel.st_key_n, panel.rs_key_n};

  // Any disagreement between the synchronised input and the accepted level must persist for
  // DEBOUNCE_CYCLES consecutive edges before it is accepted; a single agreeing edge restarts it.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < NumCh; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q      <= '1;
      sync2_q      <= '1;
      stable_q     <= '1;
      stable_dly_q <= '1;
      press_q      <= '0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      press_q      <= stable_dly_q & ~stable_q;
      cnt_q        <= cnt_d;
    end
  end

  assign rst_req = ~stable_q[ChRs] | ~stable_q[ChKey];

  // A renewed request while stretching returns to StAssert, so overlapping RS/KEY presses give
  // one unbroken core reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
`ifdef PANEL_POR_EN
      state_q     <= StStretch;
      kim_reset_q <= 1'b1;
`else
      state_q     <= StRun;
      kim_reset_q <= 1'b0;
`endif
      hold_q      <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          hold_q <= '0;
          if (rst_req) begin
            state_q     <= StAssert;
            kim_reset_q <= 1'b1;
          end else begin
            kim_reset_q <= 1'b0;
          end
        end
        StAssert: begin
          kim_reset_q <= 1'b1;
          hold_q      <= '0;
          if (!rst_req) begin
            state_q <= StStretch;
          end
        end
        StStretch: begin
          if (rst_req) begin
            state_q     <= StAssert;
            kim_reset_q <= 1'b1;
            hold_q      <= '0;
          end else if (hold_q == HoldLast) begin
            state_q     <= StRun;
            kim_reset_q <= 1'b0;
            hold_q      <= '0;
          end else begin
            kim_reset_q <= 1'b1;
            hold_q      <= hold_q + HoldW'(1);
          end
        end
        default: begin
          state_q     <= StRun;
          kim_reset_q <= 1'b0;
          hold_q      <= '0;
        end
      endcase
    end
  end

  assign panel.kim_reset   = kim_reset_q;
  assign panel.kim_nmi     = ~stable_q[ChSt];
  assign panel.sst_on      = ~stable_q[ChSst];
  assign panel.tty_on      = ~stable_q[ChTty];
  assign panel.press_pulse = press_q;

endmodule

// File: tb/tb_kim_panel_conditioner.sv
// Self-checking bench for kim_panel_conditioner: directed scenarios plus a randomized run
// compared against a sliding-window reference model of the debounce and reset-stretch rules.
module tb_kim_panel_conditioner;

  localparam int DB   = 8;
  localparam int HOLD = 4;
  localparam int MAXE = 8192;
`ifdef PANEL_POR_EN
  localparam bit POR = 1'b1;
`else
  localparam bit POR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;

  kim_panel_if pif ();

  kim_panel_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .RESET_HOLD     (HOLD)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .panel  (pif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model, indexed by posedge number.
  int         ec = 0;
  logic [4:0] hist_m  [MAXE];
  logic [4:0] stab_m  [MAXE];
  logic [4:0] pulse_m [MAXE];
  bit         kres_m  [MAXE];
  int         last_clear [5];
  int         last_rst = -1000;
  logic [4:0] raw_s;
  logic [4:0] st_s;
  bit         ok_s;
  bit         kres_s;
  int         lo_s;

  // A channel accepts a new level once the last DB synchronised samples (raw delayed two edges)
  // all disagree with the accepted level, and none of those edges precede a reset or the
  // previous acceptance. Core reset is high while a request was seen within HOLD+1 edges.
  always @(posedge clk) begin
    if (ec >= MAXE) begin
      $display("FAIL model_overflow got %0d want <%0d", ec, MAXE);
      $fatal(1);
    end
    raw_s = {pif.key_n, pif.tty_en_n, pif.sst_sw_n, pif.st_key_n, pif.rs_key_n};
    st_s  = (ec == 0) ? 5'h1f : stab_m[ec-1];
    if (!reset_n) begin
      hist_m[ec]  = 5'h1f;
      st_s        = 5'h1f;
      last_rst    = ec;
      for (int c = 0; c < 5; c++) last_clear[c] = ec + 1;
      pulse_m[ec] = 5'h00;
      kres_m[ec]  = POR;
    end else begin
      hist_m[ec] = raw_s;
      for (int c = 0; c < 5; c++) begin
        if (ec - DB >= last_clear[c]) begin
          ok_s = 1'b1;
          for (int m = 0; m < DB; m++) if (hist_m[ec-2-m][c] == st_s[c]) ok_s = 1'b0;
          if (ok_s) begin
            st_s[c]       = ~st_s[c];
            last_clear[c] = ec;
          end
        end
      end
      pulse_m[ec] = (ec >= 2) ? (stab_m[ec-2] & ~stab_m[ec-1]) : 5'h00;
      kres_s = POR && (ec - last_rst < HOLD);
      lo_s   = (ec - HOLD - 1 > last_rst + 1) ? ec - HOLD - 1 : last_rst + 1;
      if (lo_s < 0) lo_s = 0;
      for (int s = lo_s; s < ec; s++) if (!stab_m[s][0] || !stab_m[s][4]) kres_s = 1'b1;
      kres_m[ec] = kres_s;
    end
    stab_m[ec] = st_s;
    ec++;
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic release_all();
    pif.rs_key_n = 1'b1;
    pif.st_key_n = 1'b1;
    pif.sst_sw_n = 1'b1;
    pif.tty_en_n = 1'b1;
    pif.key_n    = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    release_all();
    idle(3);
    checks++;
    if ({pif.kim_nmi, pif.sst_on, pif.tty_on} !== 3'b000) begin
      errors++;
      $display("FAIL reset_levels got %b want 000", {pif.kim_nmi, pif.sst_on, pif.tty_on});
    end
    checks++;
    if (pif.press_pulse !== 5'h00) begin
      errors++;
      $display("FAIL reset_pulse got %b want 00000", pif.press_pulse);
    end
    checks++;
    if (pif.kim_reset !== POR) begin
      errors++;
      $display("FAIL reset_kim_reset got %b want %b", pif.kim_reset, POR);
    end
    reset_n = 1'b1;
    idle(HOLD + 4);
    checks++;
    if (pif.kim_reset !== 1'b0) begin
      errors++;
      $display("FAIL reset_settled got %b want 0", pif.kim_reset);
    end
  endtask

  // ST held low: kim_nmi rises DB+1 edges after the first low sample, pulse one edge later.
  task automatic test_st_press();
    logic [4:0] want_p;
    pif.st_key_n = 1'b0;
    for (int j = 0; j < 15; j++) begin
      cyc();
      want_p = (j == DB + 2) ? 5'b00010 : 5'b00000;
      checks++;
      if (pif.kim_nmi !== (j >= DB + 1)) begin
        errors++;
        $display("FAIL st_nmi edge %0d got %b want %b", j, pif.kim_nmi, (j >= DB + 1));
      end
      checks++;
      if (pif.press_pulse !== want_p) begin
        errors++;
        $display("FAIL st_pulse edge %0d got %b want %b", j, pif.press_pulse, want_p);
      end
    end
    pif.st_key_n = 1'b1;
    for (int j = 0; j < DB + 4; j++) begin
      cyc();
      checks++;
      if (pif.press_pulse !== 5'h00) begin
        errors++;
        $display("FAIL st_release_pulse edge %0d got %b want 00000", j, pif.press_pulse);
      end
    end
    checks++;
    if (pif.kim_nmi !== 1'b0) begin
      errors++;
      $display("FAIL st_release got %b want 0", pif.kim_nmi);
    end
  endtask

  task automatic test_glitch();
    pif.st_key_n = 1'b0;
    for (int j = 0; j < 20; j++) begin
      cyc();
      if (j == 4) pif.st_key_n = 1'b1;
      checks++;
      if (pif.kim_nmi !== 1'b0 || pif.press_pulse !== 5'h00) begin
        errors++;
        $display("FAIL glitch edge %0d got nmi=%b pulse=%b want nmi=0 pulse=00000",
                 j, pif.kim_nmi, pif.press_pulse);
      end
    end
  endtask

  // RS low for 20 samples; with_key adds a KEY press landing while the stretch is running.
  task automatic test_rs_stretch(input bit with_key);
    int         last_hi;
    logic [4:0] want_p;
    bit         want_r;
    last_hi      = with_key ? 45 : 33;
    pif.rs_key_n = 1'b0;
    for (int j = 0; j < 56; j++) begin
      cyc();
      want_r = (j >= DB + 2) && (j <= last_hi);
      want_p = (j == DB + 2) ? 5'b00001 : 5'b00000;
      if (with_key && j == 32) want_p = 5'b10000;
      checks++;
      if (pif.kim_reset !== want_r) begin
        errors++;
        $display("FAIL stretch%0d_reset edge %0d got %b want %b", with_key, j, pif.kim_reset,
                 want_r);
      end
      checks++;
      if (pif.press_pulse !== want_p) begin
        errors++;
        $display("FAIL stretch%0d_pulse edge %0d got %b want %b", with_key, j,
                 pif.press_pulse, want_p);
      end
      pif.rs_key_n = (j + 1 < 20) ? 1'b0 : 1'b1;
      pif.key_n    = (with_key && j + 1 >= 22 && j + 1 < 32) ? 1'b0 : 1'b1;
    end
    idle(4);
  endtask

  task automatic test_por();
    reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      cyc();
      checks++;
      if (pif.kim_reset !== (POR && j <= HOLD - 2)) begin
        errors++;
        $display("FAIL por edge %0d got %b want %b", j, pif.kim_reset, (POR && j <= HOLD - 2));
      end
    end
  endtask

  task automatic test_reset_clears();
    logic [4:0] want_p;
    pif.tty_en_n = 1'b0;
    idle(DB + 3);
    checks++;
    if (pif.tty_on !== 1'b1) begin
      errors++;
      $display("FAIL tty_on got %b want 1", pif.tty_on);
    end
    reset_n = 1'b0;
    cyc();
    checks++;
    if (pif.tty_on !== 1'b0 || pif.press_pulse !== 5'h00) begin
      errors++;
      $display("FAIL tty_reset got tty=%b pulse=%b want tty=0 pulse=00000", pif.tty_on,
               pif.press_pulse);
    end
    idle(2);
    reset_n = 1'b1;
    for (int j = 0; j < 15; j++) begin
      cyc();
      want_p = (j == DB + 2) ? 5'b01000 : 5'b00000;
      checks++;
      if (pif.tty_on !== (j >= DB + 1)) begin
        errors++;
        $display("FAIL tty_reaccept edge %0d got %b want %b", j, pif.tty_on, (j >= DB + 1));
      end
      checks++;
      if (pif.press_pulse !== want_p) begin
        errors++;
        $display("FAIL tty_pulse edge %0d got %b want %b", j, pif.press_pulse, want_p);
      end
    end
    pif.tty_en_n = 1'b1;
    idle(DB + 4);
  endtask

  task automatic test_random();
    int         hold[5];
    int         rcnt;
    logic [4:0] lvl;
    logic [8:0] got;
    logic [8:0] want;
    int         i;
    lvl  = 5'h1f;
    rcnt = 0;
    for (int c = 0; c < 5; c++) hold[c] = 0;
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      cyc();
      i    = ec - 1;
      want = {kres_m[i], ~stab_m[i][1], ~stab_m[i][2], ~stab_m[i][3], pulse_m[i]};
      got  = {pif.kim_reset, pif.kim_nmi, pif.sst_on, pif.tty_on, pif.press_pulse};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random edge %0d got %b want %b", i, got, want);
      end
      if (!reset_n) begin
        if (rcnt == 0) reset_n = 1'b1;
        else rcnt--;
      end else if ($urandom_range(0, 249) == 0) begin
        reset_n = 1'b0;
        rcnt    = int'($urandom_range(0, 2));
      end
      for (int c = 0; c < 5; c++) begin
        if (hold[c] == 0) begin
          lvl[c]  = 1'($urandom_range(0, 1));
          hold[c] = int'($urandom_range(1, 2 * DB + 4));
        end else begin
          hold[c]--;
        end
      end
      {pif.key_n, pif.tty_en_n, pif.sst_sw_n, pif.st_key_n, pif.rs_key_n} = lvl;
    end
    reset_n = 1'b1;
    release_all();
    idle(DB + HOLD + 6);
  endtask

  initial begin
    test_reset();
    test_st_press();
    test_glitch();
    test_rs_stretch(1'b0);
    test_rs_stretch(1'b1);
    test_por();
    test_reset_clears();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
